// File: rtl/audio_window_stats.sv
// Streaming per-channel min / max / peak-to-peak over windows of WIN_LEN interleaved samples.
// After each window one record per channel is drained in channel order; one-shot or continuous.
module audio_window_stats #(
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 2,
    parameter int WIN_LEN = 100,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [DATA_W-1:0] m_max,
    output logic [DATA_W-1:0] m_min,
    output logic [DATA_W:0]   m_p2p,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CH_W-1:0]          r_ch;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_done;
    logic signed [DATA_W-1:0] r_min [NUM_CH];
    logic signed [DATA_W-1:0] r_max [NUM_CH];

    logic w_in_hs;
    logic w_out_hs;
    logic w_last_ch;
    logic w_last_cnt;

    assign w_in_hs    = (r_state == S_ACCUM) && s_valid;
    assign w_out_hs   = (r_state == S_DRAIN) && m_ready;
    assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
    assign w_last_cnt = (r_cnt == CNT_W'(WIN_LEN - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                s_ready = 1'b1;
                if (w_in_hs && w_last_ch && w_last_cnt) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                m_valid = 1'b1;
                if (w_out_hs && w_last_ch) w_state_nxt = continuous ? S_ACCUM : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Channel index walks samples in ACCUM and records in DRAIN; sample count advances on channel wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_hs && w_last_ch;
            case (r_state)
                S_ACCUM: begin
                    if (w_in_hs) begin
                        if (w_last_ch) begin
                            r_ch  <= '0;
                            r_cnt <= w_last_cnt ? '0 : r_cnt + 1'b1;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_cnt <= '0;
                    if (w_out_hs) r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
                end
                default: begin
                    r_ch  <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // NOTE: the min/max storage is deliberately not reset; the first sample of each window
    // overwrites it and outputs are gated to DRAIN, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (!reset && w_in_hs) begin
            if (r_cnt == '0) begin
                r_min[r_ch] <= $signed(s_data);
                r_max[r_ch] <= $signed(s_data);
            end else begin
                if ($signed(s_data) < r_min[r_ch]) r_min[r_ch] <= $signed(s_data);
                if ($signed(s_data) > r_max[r_ch]) r_max[r_ch] <= $signed(s_data);
            end
        end
    end

    // Peak-to-peak is taken on sign-extended operands, one bit wider, so it can never wrap.
    always_comb begin
        m_ch  = '0;
        m_max = '0;
        m_min = '0;
        m_p2p = '0;
        if (r_state == S_DRAIN) begin
            m_ch  = r_ch;
            m_max = r_max[r_ch];
            m_min = r_min[r_ch];
            m_p2p = {r_max[r_ch][DATA_W-1], r_max[r_ch]} - {r_min[r_ch][DATA_W-1], r_min[r_ch]};
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_audio_window_stats.sv
// Bench for audio_window_stats: table of windows with hand-derived expected records,
// a scoreboard queue popped on output handshakes, plus continuous and mid-window reset sequences.
module tb_audio_window_stats;
    localparam int DW = 8;
    localparam int NC = 2;
    localparam int WL = 4;
    localparam int NS = NC * WL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [0:0]    m_ch;
    logic [DW-1:0] m_max;
    logic [DW-1:0] m_min;
    logic [DW:0]   m_p2p;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    audio_window_stats #(.DATA_W(DW), .NUM_CH(NC), .WIN_LEN(WL)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
        .m_max(m_max), .m_min(m_min), .m_p2p(m_p2p),
        .busy(busy), .done(done)
    );

    typedef struct {
        int s  [NS];
        int mx [NC];
        int mn [NC];
        int pp [NC];
        bit gaps;
        int bp;
        bit poke;
    } vec_t;

    typedef struct {
        int ch;
        int mx;
        int mn;
        int pp;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   done_cnt  = 0;
    bit   last_cont = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Output monitor: samples on the falling edge, a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (done) begin
                done_cnt++;
                check("s_ready_in_done_cycle", int'(s_ready), int'(last_cont));
            end
            if (m_valid) check("s_ready_low_in_drain", int'(s_ready), 0);
            if (m_valid && m_ready) begin
                check("record_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rec_ch",  int'(m_ch), e.ch);
                    check("rec_max", int'($signed(m_max)), e.mx);
                    check("rec_min", int'($signed(m_min)), e.mn);
                    check("rec_p2p", int'(m_p2p), e.pp);
                    if (e.ch == NC - 1) last_cont = continuous;
                end
            end
        end
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_s_ready"}, int'(s_ready), 0);
        check({pfx, "_m_valid"}, int'(m_valid), 0);
        check({pfx, "_busy"},    int'(busy), 0);
        check({pfx, "_done"},    int'(done), 0);
        check({pfx, "_m_ch"},    int'(m_ch), 0);
        check({pfx, "_m_max"},   int'(m_max), 0);
        check({pfx, "_m_min"},   int'(m_min), 0);
        check({pfx, "_m_p2p"},   int'(m_p2p), 0);
    endtask

    task automatic push_exp(input vec_t v);
        for (int c = 0; c < NC; c++) exp_q.push_back('{ch: c, mx: v.mx[c], mn: v.mn[c], pp: v.pp[c]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers the first n samples of v; gaps put junk on s_data with s_valid low.
    task automatic feed(input vec_t v, input bit poke, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            int k;
            bit acc;
            g = v.gaps ? int'($urandom_range(2)) : 0;
            for (int j = 0; j < g; j++) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = DW'(v.s[i]);
            if (poke) start = 1'b1;
            k   = 0;
            acc = 1'b0;
            while (!acc && k < 50) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
                k++;
            end
            check("sample_accepted", int'(acc), 1);
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic finish_window(input string tag, input int d0, input int windows);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, int'(busy), 0);
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, windows);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int d0;
        d0 = done_cnt;
        push_exp(v);
        m_ready = (v.bp == 0);
        pulse_start();
        feed(v, v.poke, NS);
        if (v.bp > 0) begin
            if (v.poke) start = 1'b1;
            for (int k = 0; k < v.bp; k++) begin
                @(negedge clk);
                check("hold_m_valid", int'(m_valid), 1);
                check("hold_ch",  int'(m_ch), exp_q[0].ch);
                check("hold_max", int'($signed(m_max)), exp_q[0].mx);
                check("hold_min", int'($signed(m_min)), exp_q[0].mn);
                check("hold_p2p", int'(m_p2p), exp_q[0].pp);
                @(posedge clk); #1;
            end
            m_ready = 1'b1;
            start   = 1'b0;
        end
        finish_window(tag, d0, 1);
    endtask

    vec_t vecs [5];
    vec_t cont_a;
    vec_t cont_b;

    initial begin
        int d0;
        vecs[0] = '{s: '{5, -100, -3, -100, 7, -100, 0, -100},
                    mx: '{7, -100}, mn: '{-3, -100}, pp: '{10, 0}, gaps: 0, bp: 0, poke: 0};
        vecs[1] = '{s: '{5, -100, -3, -100, 7, -100, 0, -100},
                    mx: '{7, -100}, mn: '{-3, -100}, pp: '{10, 0}, gaps: 1, bp: 5, poke: 1};
        vecs[2] = '{s: '{127, 1, -128, 1, 0, 1, 0, 1},
                    mx: '{127, 1}, mn: '{-128, 1}, pp: '{255, 0}, gaps: 0, bp: 0, poke: 0};
        vecs[3] = '{s: '{-1, 10, -2, 20, -3, 30, -4, 40},
                    mx: '{-1, 40}, mn: '{-4, 10}, pp: '{3, 30}, gaps: 0, bp: 0, poke: 0};
        vecs[4] = '{s: '{3, -128, 3, 127, -5, -128, 3, 127},
                    mx: '{3, 127}, mn: '{-5, -128}, pp: '{8, 255}, gaps: 1, bp: 2, poke: 0};
        cont_a  = '{s: '{1, 0, 2, 0, 3, 0, 4, 0},
                    mx: '{4, 0}, mn: '{1, 0}, pp: '{3, 0}, gaps: 0, bp: 0, poke: 0};
        cont_b  = '{s: '{9, -7, 9, -7, 9, -7, 9, -7},
                    mx: '{9, -7}, mn: '{9, -7}, pp: '{0, 0}, gaps: 0, bp: 0, poke: 0};

        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Two back-to-back windows; continuous drops during the second drain.
        d0         = done_cnt;
        continuous = 1'b1;
        m_ready    = 1'b1;
        push_exp(cont_a);
        push_exp(cont_b);
        pulse_start();
        feed(cont_a, 1'b0, NS);
        feed(cont_b, 1'b0, NS);
        continuous = 1'b0;
        finish_window("continuous", d0, 2);

        // Reset three samples into a window, then a fresh full window.
        pulse_start();
        feed(vecs[2], 1'b0, 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(vecs[3], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/audio_window_stats.md
Name: audio_window_stats

Overview:
Streaming, parametrised successor to the single-shot audio min/max block. It accepts interleaved multi-channel signed audio samples over a valid/ready stream and accumulates per-channel min, max and peak-to-peak over a window of WIN_LEN samples per channel. It then emits one result record per channel over a valid/ready output. It runs either one-shot (per start pulse) or continuously (back-to-back windows), and sits between the sample source and the level-metering / normalisation logic.

Parameters:
DATA_W, 32, sample width (signed two's complement), min 2
NUM_CH, 2, interleaved channel count, min 1
WIN_LEN, 100, samples per channel per window, min 1
CH_W, $clog2(NUM_CH) (min 1), channel index width; localparam, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a run; sampled only in IDLE
continuous  in  1  level; sampled at end of each window's output drain
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DATA_W  signed sample; channel implied by arrival order (ch0, ch1, ... ch NUM_CH-1, ch0, ...)
m_valid  out  1  result record valid
m_ready  in  1  downstream accepts record
m_ch  out  CH_W  channel of current record
m_max  out  DATA_W  signed max of window
m_min  out  DATA_W  signed min of window
m_p2p  out  DATA_W+1  unsigned max - min
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last record of a window is accepted

Behaviour:
- Reset (reset high at a clock edge): state IDLE; s_ready, m_valid, busy and done are 0; m_ch, m_max, m_min and m_p2p are 0.
- Reset overrides everything, including mid-window and mid-drain. Partial results are discarded, and the channel and sample counters clear.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - s_ready=0, m_valid=0.
  - start=1 -> ACCUM next cycle; channel counter = 0, sample counter = 0.
  - start is ignored in every other state.
- ACCUM:
  - s_ready=1.
  - On each s_valid&&s_ready, update the per-channel registers of the current channel index, then advance the index, wrapping NUM_CH-1 -> 0. On wrap, increment the per-channel sample count.
  - First sample of a channel in a window loads both min and max for that channel. No sentinel initial values are used.
  - Later samples use a signed compare: min <= s_data if s_data < min; max <= s_data if s_data > max. Equal values leave the register unchanged.
  - After the handshake that completes NUM_CH*WIN_LEN samples -> DRAIN. s_ready drops in the following cycle; no extra sample is accepted.
- DRAIN:
  - s_ready=0.
  - Records are presented in channel order 0..NUM_CH-1.
  - m_valid rises in the cycle after the final input handshake, so latency is 1 cycle.
  - While m_valid=1 and m_ready=0, m_ch/m_max/m_min/m_p2p must be held stable.
  - On m_valid&&m_ready, advance to the next channel. Back-to-back records are allowed, one per cycle, when m_ready is held high.
  - m_p2p = sign-extended max minus sign-extended min, computed at DATA_W+1 bits. It never overflows and is always >= 0.
- End of DRAIN (last channel handshake):
  - done=1 for exactly the next cycle.
  - If continuous=1 at that handshake edge -> ACCUM with counters cleared; the first new sample can be accepted in that same done cycle.
  - Otherwise -> IDLE.
- m_ready is ignored when m_valid=0. s_valid is ignored when s_ready=0.
- NUM_CH=1: channel index is constant 0; m_ch stays 0.
- WIN_LEN=1: min=max=the sample; p2p=0.

Test Plan:
1. NUM_CH=2, WIN_LEN=4, one-shot, m_ready=1. Samples ch0: 5,-3,7,0; ch1: -100,-100,-100,-100 (interleaved). Required: record0 max=7, min=-3, p2p=10; record1 max=-100, min=-100, p2p=0; done pulses once; return to IDLE.
2. DATA_W=8, NUM_CH=1, WIN_LEN=3. Samples 127,-128,0. Required: max=127, min=-128, m_p2p=255 (9-bit), no wrap.
3. Input gaps plus output backpressure. s_valid toggles randomly; m_ready is held low 5 cycles at record0. Required: record0 fields stable throughout; results equal the gap-free case; s_ready=0 for the whole drain.
4. continuous=1, two windows of data ch0: 1,2,3,4 then 9,9,9,9. Required: second window reports min=9, max=9, with no carry-over from the first. Drop continuous before the second drain ends -> IDLE.
5. reset asserted after 3 of 8 samples. Required: all outputs 0 next cycle, IDLE. A new start followed by a full window gives correct fresh results.
6. start asserted during ACCUM and during DRAIN. Required: no effect on counters or results.
